// File: rtl/bf16_mac_pkg.sv
// -----------------------------------------------------------------------------
// bf16_mac_pkg
// Shared definitions for the bfloat16 dot-product sequencer and its benches:
//   - seq_state_t : sequencer state encoding (IDLE/RUN/DRAIN/DONE)
//   - BF16_ZERO   : bfloat16 +0.0
//   - CNTL_ACC    : bfloat_mac2 cntl value for out <= out + a*b
//   - CNTL_LOAD   : bfloat_mac2 cntl value for out <= a*b
//   - BF16_ONE/HALF/TWO : handy bfloat16 constants for directed tests
// -----------------------------------------------------------------------------
package bf16_mac_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    localparam logic [15:0] BF16_ZERO = 16'h0000;
    localparam logic [15:0] BF16_ONE  = 16'h3F80;
    localparam logic [15:0] BF16_HALF = 16'h3F00;
    localparam logic [15:0] BF16_TWO  = 16'h4000;

    localparam logic CNTL_ACC  = 1'b0;
    localparam logic CNTL_LOAD = 1'b1;

endpackage

// File: rtl/bf16_dot_seq.sv
// -----------------------------------------------------------------------------
// bf16_dot_seq
// Time-shares one bfloat_mac2 multiply-accumulate unit to compute one
// bfloat16 dot product per job.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   job_valid/job_ready   job request handshake, job_len = number of pairs
//   op_valid/op_ready     operand pair handshake, op_a/op_b bfloat16 operands
//   mac_a/mac_b/mac_cntl  drive the MAC inputs (combinational)
//   mac_out               registered MAC accumulator output
//   res_valid/res_ready   result handshake, res_data = bfloat16 dot product
//   busy                  high whenever the sequencer is not idle
//
// The first accepted pair of every job uses CNTL_LOAD, so whatever the MAC
// held before (including a job cut short by reset) never leaks into a result.
// Bubbles and all non-RUN cycles feed +0 * +0 with CNTL_ACC so the
// accumulator holds its value.
// -----------------------------------------------------------------------------
module bf16_dot_seq
    import bf16_mac_pkg::*;
#(
    parameter int   LEN_W     = 8,
    parameter int   MAC_LAT   = 1,
    parameter logic CNTL_ACC  = bf16_mac_pkg::CNTL_ACC,
    parameter logic CNTL_LOAD = bf16_mac_pkg::CNTL_LOAD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    output logic             mac_cntl,
    input  logic [15:0]      mac_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             busy
);

    // Drain counter must hold MAC_LAT; keep at least one bit for MAC_LAT=0.
    localparam int DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    seq_state_t         state_q,     state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               first_q,     first_d;
    logic [DRAIN_W-1:0] drain_q,     drain_d;
    logic [15:0]        res_data_q,  res_data_d;

    // State register and datapath flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= {LEN_W{1'b0}};
            first_q     <= 1'b0;
            drain_q     <= {DRAIN_W{1'b0}};
            res_data_q  <= BF16_ZERO;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            drain_q     <= drain_d;
            res_data_q  <= res_data_d;
        end
    end

    // Next-state logic and MAC input steering.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        drain_d     = drain_q;
        res_data_d  = res_data_q;
        mac_a       = BF16_ZERO;
        mac_b       = BF16_ZERO;
        mac_cntl    = CNTL_ACC;

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    if (job_len == {LEN_W{1'b0}}) begin
                        res_data_d = BF16_ZERO;
                        state_d    = S_DONE;
                    end else begin
                        remaining_d = job_len;
                        first_d     = 1'b1;
                        state_d     = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                if (op_valid) begin
                    mac_a       = op_a;
                    mac_b       = op_b;
                    mac_cntl    = first_q ? CNTL_LOAD : CNTL_ACC;
                    first_d     = 1'b0;
                    remaining_d = remaining_q - {{(LEN_W-1){1'b0}}, 1'b1};
                    if (remaining_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        drain_d = DRAIN_W'(MAC_LAT);
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    // Bubble: zeros with ACC leave the accumulator unchanged.
                    state_d = S_RUN;
                end
            end

            S_DRAIN: begin
                // The last product reaches mac_out MAC_LAT cycles after the
                // final pair; capture one cycle after the count runs out.
                if (drain_q == {DRAIN_W{1'b0}}) begin
                    res_data_d = mac_out;
                    state_d    = S_DONE;
                end else begin
                    drain_d = drain_q - {{(DRAIN_W-1){1'b0}}, 1'b1};
                end
            end

            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake flags decode directly from the state flop.
    assign job_ready = (state_q == S_IDLE);
    assign op_ready  = (state_q == S_RUN);
    assign res_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign res_data  = res_data_q;

endmodule

// File: doc/bf16_dot_seq.md
Name: bf16_dot_seq

Overview:
- Job sequencer that time-shares the bfloat16 multiply-accumulate unit (bfloat_mac2) to compute one dot product per job.
- Accepts a job of N operand pairs, streams them into the MAC with correct load/accumulate control, waits out the MAC latency, then returns the 16-bit bfloat16 result over a valid/ready handshake.
- Sits between the operand-supply logic and the bfloat_mac2 instance; it owns the MAC's a, b and cntl inputs.

Parameters:
- LEN_W, 8, width of job length field; max job length is 2^LEN_W-1 pairs.
- MAC_LAT, 1, cycles from MAC input sample to valid mac_out (bfloat_mac2 output is registered: 1).
- CNTL_ACC, 1'b0, cntl encoding for out <= out + a*b.
- CNTL_LOAD, 1'b1, cntl encoding for out <= a*b (accumulator restart).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  job request
- job_ready  out  1  job accepted when job_valid & job_ready
- job_len  in  LEN_W  number of operand pairs in job
- op_valid  in  1  operand pair valid
- op_ready  out  1  operand pair consumed when op_valid & op_ready
- op_a  in  16  bfloat16 operand a
- op_b  in  16  bfloat16 operand b
- mac_a  out  16  to bfloat_mac2 a
- mac_b  out  16  to bfloat_mac2 b
- mac_cntl  out  1  to bfloat_mac2 cntl
- mac_out  in  16  from bfloat_mac2 out
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when res_valid & res_ready
- res_data  out  16  bfloat16 dot-product result
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, job_ready=1, op_ready=0, res_valid=0, res_data=16'h0000, mac_a=mac_b=16'h0000, mac_cntl=CNTL_ACC, busy=0, all counters 0.
- mac_a/mac_b/mac_cntl are combinational from state and op handshake.
- IDLE: job_ready=1.
  - On job accept with job_len=0: res_data<=16'h0000, go to DONE.
  - Otherwise latch remaining<=job_len, first<=1, go to RUN.
- RUN: op_ready=1, job_ready=0.
  - Each cycle with op_valid: mac_a=op_a, mac_b=op_b, mac_cntl=first ? CNTL_LOAD : CNTL_ACC; first<=0; remaining decrements.
  - Bubble (op_valid=0): mac_a=mac_b=16'h0000, mac_cntl=CNTL_ACC so the accumulator holds (adds +0).
  - When the last pair is accepted (remaining==1), load drain<=MAC_LAT and go to DRAIN.
- DRAIN: op_ready=0, MAC driven with zeros/ACC; drain decrements each cycle. When drain reaches 0, capture res_data<=mac_out and go to DONE. Total latency from last pair accept to res_valid = MAC_LAT+1 cycles.
- DONE: res_valid=1, res_data stable.
  - On res_ready: res_valid<=0, go to IDLE.
  - job_ready=0 in DONE, so no new job overlaps an undelivered result.
- op_ready is 0 outside RUN; op_valid outside RUN is ignored and the MAC sees zeros/ACC.
- Job length is fixed at accept; job_len changes afterwards have no effect.
- Accumulator restart relies solely on CNTL_LOAD on the first pair. There is no dependence on the prior MAC contents.
- Reset asserted mid-job: immediate return to reset values. The partial result is discarded; the next job's first pair uses LOAD.
- States are encoded in a 2-bit enum: IDLE, RUN, DRAIN, DONE. Illegal encodings go to IDLE.

Decomposition:
- Package bf16_mac_pkg holds:
  - state enum seq_state_t (IDLE/RUN/DRAIN/DONE)
  - BF16_ZERO=16'h0000
  - CNTL_ACC/CNTL_LOAD constants
  - bfloat16 constants used by benches: ONE=16'h3F80, HALF=16'h3F00, TWO=16'h4000
- No sub-module is needed; the bench instantiates bf16_dot_seq together with bfloat_mac2.

Test Plan:
- Basic dot product: job_len=2, pairs (3F80,3F80),(3F00,3F00) back-to-back → res_data=16'h3FA0 (1.25), res_valid MAC_LAT+1 cycles after the last op accept.
- Accumulator restart: immediately after the previous job, job_len=1 pair (4000,4000) → res_data=16'h4080 (4.0), not 5.25; mac_cntl=LOAD on that pair.
- Operand bubbles: job_len=2 with op_valid low for 3 cycles between pairs → res_data=16'h3FA0; mac_a=mac_b=0 and mac_cntl=ACC during gaps.
- Zero length: job_len=0 → res_valid next cycle, res_data=16'h0000, no op_ready pulse.
- Result backpressure: hold res_ready=0 for 5 cycles → res_valid and res_data stable, job_ready=0, busy=1; after release, job_ready=1 the cycle after the handshake.
- Reset mid-RUN: assert rst_n=0 after 1 of 3 pairs → all outputs at reset values; a new job_len=1 (3F80,3F80) → 16'h3F80.
